seg_scan_driver: RTL and testbench

Parametrised, time-multiplexed driver for common-anode seven-segment displays with N digits. It captures a packed hex value with per-digit decimal-point and enable bits, commits it tear-free at frame boundaries, and scans one active-low anode at a time. Each digit slot has guard-band blanking to suppress ghosting. It sits between the datapath/register outputs and the board display pins, and replaces the fixed 8-digit rotator/decoder pair.

---
 rtl/seg_pkg.sv | 41 ++++
 rtl/seg_scan_driver_if.sv | 13 +
 rtl/seg_hex_decoder.sv | 9 +
 rtl/seg_scan_driver.sv | 90 +++++++++
 tb/tb_seg_scan_driver.sv | 130 +++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment constants and hex decode for the scan driver.
package seg_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0 = 7'h01;
    localparam logic [6:0] SEG_1 = 7'h4F;
    localparam logic [6:0] SEG_2 = 7'h12;
    localparam logic [6:0] SEG_3 = 7'h06;
    localparam logic [6:0] SEG_4 = 7'h4C;
    localparam logic [6:0] SEG_5 = 7'h24;
    localparam logic [6:0] SEG_6 = 7'h20;
    localparam logic [6:0] SEG_7 = 7'h0F;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h04;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h60;
    localparam logic [6:0] SEG_C = 7'h31;
    localparam logic [6:0] SEG_D = 7'h42;
    localparam logic [6:0] SEG_E = 7'h30;
    localparam logic [6:0] SEG_F = 7'h38;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        case (nibble)
            4'h0: seg_decode = SEG_0;
            4'h1: seg_decode = SEG_1;
            4'h2: seg_decode = SEG_2;
            4'h3: seg_decode = SEG_3;
            4'h4: seg_decode = SEG_4;
            4'h5: seg_decode = SEG_5;
            4'h6: seg_decode = SEG_6;
            4'h7: seg_decode = SEG_7;
            4'h8: seg_decode = SEG_8;
            4'h9: seg_decode = SEG_9;
            4'hA: seg_decode = SEG_A;
            4'hB: seg_decode = SEG_B;
            4'hC: seg_decode = SEG_C;
            4'hD: seg_decode = SEG_D;
            4'hE: seg_decode = SEG_E;
            default: seg_decode = SEG_F;
        endcase
    endfunction
endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: capture inputs from the datapath and display pin outputs.
interface seg_scan_driver_if #(parameter int NUM_DIGITS = 8);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   anode;
    logic                    frame_done;
    modport master (output value, dp_in, digit_en, load, input seg, dp, anode, frame_done);
    modport slave (input value, dp_in, digit_en, load, output seg, dp, anode, frame_done);
endinterface

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: combinational nibble to active-low segment pattern.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = seg_decode(nibble);
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: tear-free multiplexed common-anode 7-seg scanner with guard blanking.
// Optional SEG_LEAD_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 2
) (
    input  logic clk,
    input  logic rst,
    seg_scan_driver_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD = CW'(GUARD_CYC);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [4*NUM_DIGITS-1:0] act_val, pend_val;
    logic [NUM_DIGITS-1:0] act_dp, act_en, pend_dp, pend_en, lz;
    logic pend_v, tick, wrap, lit, show;
    logic [6:0] dec;

    assign tick = cnt == CNT_MAX;
    assign wrap = tick && idx == IDX_MAX;
    assign lit  = cnt >= GUARD;
    assign show = lit && act_en[idx] && !lz[idx];

    seg_hex_decoder u_dec (.nibble(act_val[{idx, 2'b00} +: 4]), .seg(dec));

`ifdef SEG_LEAD_ZERO_BLANK_EN
    logic lz_run;
    always_comb begin
        lz = '0;
        lz_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run = lz_run && act_val[4*i +: 4] == 4'h0;
            lz[i] = lz_run;
        end
    end
`else
    assign lz = '0;
`endif

    // Enables come out of reset all-on so a freshly reset display reads zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
            act_val <= '0;
            act_dp <= '0;
            act_en <= '1;
            pend_val <= '0;
            pend_dp <= '0;
            pend_en <= '0;
            pend_v <= 1'b0;
            bus.anode <= '1;
            bus.seg <= SEG_BLANK;
            bus.dp <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) idx <= idx == IDX_MAX ? '0 : idx + 1'b1;
            if (wrap && bus.load) begin
                act_val <= bus.value;
                act_dp <= bus.dp_in;
                act_en <= bus.digit_en;
                pend_v <= 1'b0;
            end else if (wrap && pend_v) begin
                act_val <= pend_val;
                act_dp <= pend_dp;
                act_en <= pend_en;
                pend_v <= 1'b0;
            end else if (bus.load) begin
                pend_val <= bus.value;
                pend_dp <= bus.dp_in;
                pend_en <= bus.digit_en;
                pend_v <= 1'b1;
            end
            bus.anode <= lit ? ~(ONE << idx) : '1;
            bus.seg <= show ? dec : SEG_BLANK;
            bus.dp <= lit && act_en[idx] ? ~act_dp[idx] : 1'b1;
            bus.frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: frame-position reference model checked every cycle.
module tb_seg_scan_driver;
    localparam int N = 4, RD = 8, G = 2, FR = N * RD;
    localparam logic [6:0] HEX [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  en;
    } disp_t;
    localparam disp_t RST_DISP = '{val: 16'h0, dp: 4'h0, en: 4'hF};

    logic clk = 1'b0, rst = 1'b1;
    disp_t act, q[$];
    int p, vec, miss;

    seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();
    seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD_CYC(G)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s p=%0d observed=%h expected=%h", tag, p, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_anode"}, bus.anode, 4'hF);
        chk({tag, "_seg"}, bus.seg, 7'h7F);
        chk({tag, "_dp"}, bus.dp, 1'b1);
        chk({tag, "_fd"}, bus.frame_done, 1'b0);
    endtask

    task automatic step();
        int slot, w;
        logic [3:0] ea;
        logic [6:0] es;
        logic edp, efd, blank;
        disp_t in;
        @(posedge clk);
        slot = (p / RD) % N;
        w = p % RD;
        ea = 4'hF;
        es = 7'h7F;
        edp = 1'b1;
        if (w >= G) begin
            ea = ~(4'b0001 << slot);
            blank = !act.en[slot];
`ifdef SEG_LEAD_ZERO_BLANK_EN
            if (slot > 0 && (act.val >> (4 * slot)) == 16'h0) blank = 1'b1;
`endif
            if (!blank) es = HEX[act.val[4*slot +: 4]];
            if (act.en[slot]) edp = ~act.dp[slot];
        end
        efd = (p % FR) == FR - 1;
        in = {bus.value, bus.dp_in, bus.digit_en};
        if (efd) begin
            if (bus.load) act = in;
            else if (q.size() > 0) act = q[$];
            q.delete();
        end else if (bus.load) q.push_back(in);
        p++;
        @(negedge clk);
        chk("anode", bus.anode, ea);
        chk("seg", bus.seg, es);
        chk("dp", bus.dp, edp);
        chk("frame_done", bus.frame_done, efd);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        bus.value = v;
        bus.dp_in = d;
        bus.digit_en = e;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    initial begin
        bus.value = '0;
        bus.dp_in = '0;
        bus.digit_en = '0;
        bus.load = 1'b0;
        act = RST_DISP;
        p = 0;
        vec = 0;
        miss = 0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        repeat (FR + 8) step();
        while (p % FR != 12) step();
        do_load(16'hA930, 4'b0010, 4'hF);
        repeat (2 * FR) step();
        while (p % FR != 5) step();
        do_load(16'h1111, 4'h0, 4'hF);
        repeat (4) step();
        do_load(16'h2222, 4'h0, 4'hF);
        repeat (2 * FR) step();
        while (p % FR != FR - 1) step();
        do_load(16'($urandom), 4'($urandom), 4'hF);
        repeat (FR + 4) step();
        do_load(16'($urandom), 4'($urandom), 4'b0101);
        repeat (2 * FR) step();
        repeat (400) begin
            if ($urandom_range(9) == 0) do_load(16'($urandom), 4'($urandom), 4'($urandom));
            else step();
        end
        while (p % FR != RD + 3) step();
        do_load(16'($urandom) | 16'h8000, 4'($urandom), 4'hF);
        while (p % FR != 2 * RD + 4) step();
        rst = 1'b1;
        #1;
        chk_reset("midrst");
        q.delete();
        act = RST_DISP;
        p = 0;
        @(negedge clk);
        chk_reset("midrst_hold");
        rst = 1'b0;
        repeat (2 * FR + 8) step();
        do_load(16'h0050, 4'h0, 4'hF);
        repeat (2 * FR) step();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
